pipeline_run_controller: RTL and testbench
==========================================

# pipeline_run_controller

Synthesisable run controller for the pipelined MIPS core: it owns the core's reset, sequences a run on command, counts executed cycles, and ends the run on an explicit halt, a stalled program counter (branch-to-self end loop), or a cycle timeout. It sits between the top-level clock/reset and `PipelineProcessorMIPS`. It replaces fixed-delay reset/finish sequencing with parameterised reset length, run budget and end-of-program detection, readable by a bench or on-board status logic.

## Interface
Parameters:
- RESET_CYCLES, 2, cycles core_rst_o is held in RESET before RUN (≥1)
- MAX_CYCLES, 60, run budget in RUN cycles before timeout (≥1, < 2^CYCLE_W)
- CYCLE_W, 16, width of cycle counter
- PC_W, 32, width of observed PC
- STALL_LIMIT, 8, consecutive valid cycles with unchanged PC that count as a halt (≥1)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- start_i  in  1  begin a run; sampled in IDLE or DONE only
- halt_i  in  1  explicit halt from core, sampled in RUN only
- pc_valid_i  in  1  pc_i is meaningful this cycle
- pc_i  in  PC_W  core PC (IF stage)
- core_rst_o  out  1  reset to core, active-high
- running_o  out  1  high in RUN
- done_o  out  1  high in DONE
- cause_o  out  2  end cause: 0 none, 1 halt_i, 2 PC stall, 3 timeout
- cycle_count_o  out  CYCLE_W  RUN cycles elapsed in current/last run

## Operation
- States: IDLE, RESET, RUN, DONE. All outputs registered.
- RST asserted: state IDLE, core_rst_o=1, running_o=0, done_o=0, cause_o=0, cycle_count_o=0, stall counter 0, last-PC-valid flag 0.
- IDLE: core_rst_o=1. start_i=1 → RESET, load reset counter with RESET_CYCLES.
- RESET: core_rst_o=1; counter decrements each cycle; on the edge it reaches 0 → RUN, cycle_count_o←0, cause_o←0, stall counter←0, last-PC-valid←0. start_i ignored.
- RUN: core_rst_o=0, running_o=1. cycle_count_o increments on every RUN edge, including the edge that leaves RUN.
- PC stall tracking in RUN: when pc_valid_i=1 and last-PC-valid=1 and pc_i==last PC, stall counter +1; when pc_valid_i=1 and PC differs (or first valid sample), stall counter←0, last PC←pc_i, last-PC-valid←1; pc_valid_i=0 holds counter and last PC.
- End conditions, evaluated each RUN cycle, priority halt > stall > timeout:
  - halt_i=1 → DONE, cause 1.
  - stall counter would reach STALL_LIMIT on this edge → DONE, cause 2.
  - cycle_count_o would reach MAX_CYCLES on this edge → DONE, cause 3.
- DONE: core_rst_o=1 (core quiesced), done_o=1, cause_o and cycle_count_o held. start_i=1 → RESET (done_o←0, cause_o←0, cycle_count_o held until RUN entry).
- start_i in RUN ignored; no abort other than RST.
- RST mid-run: immediate asynchronous return to IDLE with reset values above; core_rst_o rises without waiting for a clock.

## Timing
- start_i high at edge t (IDLE) → RESET after t; RUN after edge t+RESET_CYCLES; core_rst_o falls after that edge, i.e. core sees exactly RESET_CYCLES+1 cycles of reset following the start edge (including the IDLE cycle).
- Cycle count: leaving RUN on the Nth RUN edge gives cycle_count_o=N in DONE.
- Timeout: DONE after exactly MAX_CYCLES RUN edges, cycle_count_o=MAX_CYCLES, cause 3.
- halt_i sampled high on the k-th RUN edge → DONE after that edge, cycle_count_o=k, core_rst_o=1 from the same edge.
- Stall: first valid sample sets the reference; DONE after STALL_LIMIT further consecutive equal valid samples.
- Counter never wraps: MAX_CYCLES < 2^CYCLE_W guaranteed by parameter check (elaboration error otherwise).

## Test plan
- Reset/idle: RST=1 for 3 cycles, release, no start → core_rst_o=1, done_o=0, cause_o=0, cycle_count_o=0 indefinitely.
- Timeout, defaults: start_i one cycle, pc_i incrementing by 4 each cycle → core_rst_o low after 2 RESET cycles, done_o after 60 RUN cycles, cause_o=3, cycle_count_o=60, core_rst_o=1.
- Explicit halt: halt_i pulsed on 10th RUN cycle → done_o next edge, cause_o=1, cycle_count_o=10; halt_i outside RUN has no effect.
- PC stall with gaps: pc_i=0x0000_0040 held, pc_valid_i toggling 1/0 → DONE only after 8 equal valid samples after the first, cause_o=2; changing pc_i to 0x44 mid-way resets the count.
- Simultaneous: halt_i=1 on the same edge as timeout and stall limit → cause_o=1; stall+timeout only → cause_o=2.
- Restart and async reset: start_i in DONE → fresh run, cause_o cleared, cycle_count_o restarts at 0; RST asserted mid-RUN between edges → core_rst_o=1 and state IDLE immediately, running_o=0.

Source files
------------

// File: rtl/pipeline_run_controller.sv
// Run controller for the pipelined MIPS core: holds the core in reset, runs it on command,
// counts RUN cycles and stops on halt, a stalled PC (end loop) or a cycle timeout.
module pipeline_run_controller #(
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned MAX_CYCLES   = 60,
    parameter int unsigned CYCLE_W      = 16,
    parameter int unsigned PC_W         = 32,
    parameter int unsigned STALL_LIMIT  = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start_i,
    input  logic               halt_i,
    input  logic               pc_valid_i,
    input  logic [PC_W-1:0]    pc_i,
    output logic               core_rst_o,
    output logic               running_o,
    output logic               done_o,
    output logic [1:0]         cause_o,
    output logic [CYCLE_W-1:0] cycle_count_o
);

    localparam int unsigned RST_W   = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES + 1);
    localparam int unsigned STALL_W = (STALL_LIMIT < 2) ? 1 : $clog2(STALL_LIMIT + 1);

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_HALT    = 2'd1;
    localparam logic [1:0] CAUSE_STALL   = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

    // Elaboration-time guard: the cycle counter must never wrap.
    if (RESET_CYCLES == 0 || STALL_LIMIT == 0 || MAX_CYCLES == 0 ||
        (64'(MAX_CYCLES) >> CYCLE_W) != 64'd0) begin : g_param_err
        $error("pipeline_run_controller: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [CYCLE_W-1:0] cycle_q, cycle_d;
    logic [1:0]         cause_q, cause_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [PC_W-1:0]    last_pc_q, last_pc_d;
    logic               last_pc_valid_q, last_pc_valid_d;
    logic               core_rst_q, core_rst_d;
    logic               running_q, running_d;
    logic               done_q, done_d;

    logic               pc_same;
    logic [STALL_W-1:0] stall_inc;
    logic [CYCLE_W-1:0] cycle_inc;

    always_comb begin
        state_d         = state_q;
        rst_cnt_d       = rst_cnt_q;
        cycle_d         = cycle_q;
        cause_d         = cause_q;
        stall_d         = stall_q;
        last_pc_d       = last_pc_q;
        last_pc_valid_d = last_pc_valid_q;
        pc_same         = pc_valid_i && last_pc_valid_q && (pc_i == last_pc_q);
        stall_inc       = stall_q + STALL_W'(1);
        cycle_inc       = cycle_q + CYCLE_W'(1);

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_RESET;
                    rst_cnt_d = RST_W'(RESET_CYCLES);
                end
            end
            S_RESET: begin
                rst_cnt_d = rst_cnt_q - RST_W'(1);
                if (rst_cnt_q <= RST_W'(1)) begin
                    state_d         = S_RUN;
                    cycle_d         = '0;
                    cause_d         = CAUSE_NONE;
                    stall_d         = '0;
                    last_pc_valid_d = 1'b0;
                end
            end
            S_RUN: begin
                cycle_d = cycle_inc;
                // An invalid PC sample leaves both the reference and the stall count alone.
                if (pc_same) begin
                    stall_d = stall_inc;
                end else if (pc_valid_i) begin
                    stall_d         = '0;
                    last_pc_d       = pc_i;
                    last_pc_valid_d = 1'b1;
                end
                if (halt_i) begin
                    state_d = S_DONE;
                    cause_d = CAUSE_HALT;
                end else if (pc_same && stall_inc == STALL_W'(STALL_LIMIT)) begin
                    state_d = S_DONE;
                    cause_d = CAUSE_STALL;
                end else if (cycle_inc == CYCLE_W'(MAX_CYCLES)) begin
                    state_d = S_DONE;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_DONE: begin
                if (start_i) begin
                    state_d   = S_RESET;
                    rst_cnt_d = RST_W'(RESET_CYCLES);
                    cause_d   = CAUSE_NONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status flags follow the next state so they are registered alongside it.
        core_rst_d = (state_d != S_RUN);
        running_d  = (state_d == S_RUN);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q         <= S_IDLE;
            rst_cnt_q       <= '0;
            cycle_q         <= '0;
            cause_q         <= CAUSE_NONE;
            stall_q         <= '0;
            last_pc_q       <= '0;
            last_pc_valid_q <= 1'b0;
            core_rst_q      <= 1'b1;
            running_q       <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            rst_cnt_q       <= rst_cnt_d;
            cycle_q         <= cycle_d;
            cause_q         <= cause_d;
            stall_q         <= stall_d;
            last_pc_q       <= last_pc_d;
            last_pc_valid_q <= last_pc_valid_d;
            core_rst_q      <= core_rst_d;
            running_q       <= running_d;
            done_q          <= done_d;
        end
    end

    assign core_rst_o    = core_rst_q;
    assign running_o     = running_q;
    assign done_o        = done_q;
    assign cause_o       = cause_q;
    assign cycle_count_o = cycle_q;

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Bench for pipeline_run_controller: each run pushes its expected end cause and cycle count
// to a scoreboard, popped and compared when done_o rises.
module tb_pipeline_run_controller;

    localparam int unsigned CYCLE_W = 16;
    localparam int unsigned PC_W    = 32;

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic               start_i = 1'b0;
    logic               halt_i = 1'b0;
    logic               pc_valid_i = 1'b0;
    logic [PC_W-1:0]    pc_i = '0;
    logic               core_rst_o;
    logic               running_o;
    logic               done_o;
    logic [1:0]         cause_o;
    logic [CYCLE_W-1:0] cycle_count_o;

    typedef struct packed {
        logic [1:0]         cause;
        logic [CYCLE_W-1:0] count;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    pipeline_run_controller #(
        .RESET_CYCLES(2), .MAX_CYCLES(60), .CYCLE_W(CYCLE_W), .PC_W(PC_W), .STALL_LIMIT(8)
    ) dut (
        .CLK(CLK), .RST(RST), .start_i(start_i), .halt_i(halt_i),
        .pc_valid_i(pc_valid_i), .pc_i(pc_i), .core_rst_o(core_rst_o),
        .running_o(running_o), .done_o(done_o), .cause_o(cause_o),
        .cycle_count_o(cycle_count_o)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Start pulse plus two RESET cycles; checks the reset window and RUN entry.
    task automatic start_run(input string tag);
        logic [CYCLE_W-1:0] held;
        held    = cycle_count_o;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n_tests++;
        if (core_rst_o !== 1'b1 || running_o !== 1'b0 || done_o !== 1'b0 ||
            cause_o !== 2'd0 || cycle_count_o !== held) begin
            n_fail++;
            $display("FAIL %s start_edge: rst=%b run=%b done=%b cause=%0d cnt=%0d, want 1 0 0 0 %0d",
                     tag, core_rst_o, running_o, done_o, cause_o, cycle_count_o, held);
        end
        tick();
        n_tests++;
        if (core_rst_o !== 1'b1 || running_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s reset_hold: rst=%b run=%b, want 1 0", tag, core_rst_o, running_o);
        end
        tick();
        n_tests++;
        if (core_rst_o !== 1'b0 || running_o !== 1'b1 || cycle_count_o !== '0 || cause_o !== 2'd0) begin
            n_fail++;
            $display("FAIL %s run_entry: rst=%b run=%b cnt=%0d cause=%0d, want 0 1 0 0",
                     tag, core_rst_o, running_o, cycle_count_o, cause_o);
        end
    endtask

    task automatic test_reset;
        repeat (3) tick();
        RST    = 1'b0;
        halt_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if (core_rst_o !== 1'b1 || running_o !== 1'b0 || done_o !== 1'b0 ||
                cause_o !== 2'd0 || cycle_count_o !== '0) begin
                n_fail++;
                $display("FAIL idle_%0d: rst=%b run=%b done=%b cause=%0d cnt=%0d, want 1 0 0 0 0",
                         i, core_rst_o, running_o, done_o, cause_o, cycle_count_o);
            end
        end
        halt_i = 1'b0;
    endtask

    task automatic test_timeout;
        int   edges;
        exp_t e;
        edges = 0;
        sb.push_back('{cause: 2'd3, count: CYCLE_W'(60)});
        start_run("timeout");
        for (int c = 1; c <= 70; c++) begin
            pc_valid_i = 1'b1;
            pc_i       = PC_W'(32'h1000 + 4 * c);
            tick();
            if (done_o) begin edges = c; break; end
        end
        pc_valid_i = 1'b0;
        e = sb.pop_front();
        n_tests++;
        if (edges != 60 || cause_o !== e.cause || cycle_count_o !== e.count ||
            core_rst_o !== 1'b1 || running_o !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout: edges=%0d cause=%0d cnt=%0d rst=%b run=%b, want 60 %0d %0d 1 0",
                     edges, cause_o, cycle_count_o, core_rst_o, running_o, e.cause, e.count);
        end
    endtask

    // Restarts from DONE; halt on the 10th RUN edge, then halt in DONE must be ignored.
    task automatic test_halt;
        int   edges;
        exp_t e;
        edges = 0;
        sb.push_back('{cause: 2'd1, count: CYCLE_W'(10)});
        start_run("halt");
        for (int c = 1; c <= 70; c++) begin
            pc_valid_i = 1'b1;
            pc_i       = PC_W'(32'h2000 + 4 * c);
            halt_i     = (c == 10);
            tick();
            if (done_o) begin edges = c; break; end
        end
        pc_valid_i = 1'b0;
        e = sb.pop_front();
        n_tests++;
        if (edges != 10 || cause_o !== e.cause || cycle_count_o !== e.count || core_rst_o !== 1'b1) begin
            n_fail++;
            $display("FAIL halt: edges=%0d cause=%0d cnt=%0d rst=%b, want 10 %0d %0d 1",
                     edges, cause_o, cycle_count_o, core_rst_o, e.cause, e.count);
        end
        halt_i = 1'b1;
        repeat (2) tick();
        halt_i = 1'b0;
        n_tests++;
        if (done_o !== 1'b1 || cause_o !== 2'd1 || cycle_count_o !== CYCLE_W'(10)) begin
            n_fail++;
            $display("FAIL halt_in_done: done=%b cause=%0d cnt=%0d, want 1 1 10", done_o, cause_o, cycle_count_o);
        end
    endtask

    // Valid on odd cycles only; samples 1..5 are 0x40, from sample 6 on 0x44 (new reference).
    // Eight more equal valid samples are 7..14, i.e. cycle 27.
    task automatic test_stall;
        int   edges;
        int   v;
        exp_t e;
        edges = 0;
        sb.push_back('{cause: 2'd2, count: CYCLE_W'(27)});
        start_run("stall");
        for (int c = 1; c <= 70; c++) begin
            v          = (c + 1) / 2;
            pc_valid_i = (c % 2) == 1;
            pc_i       = pc_valid_i ? ((v <= 5) ? 32'h0000_0040 : 32'h0000_0044) : PC_W'($urandom);
            tick();
            if (done_o) begin edges = c; break; end
        end
        pc_valid_i = 1'b0;
        e = sb.pop_front();
        n_tests++;
        if (edges != 27 || cause_o !== e.cause || cycle_count_o !== e.count) begin
            n_fail++;
            $display("FAIL stall: edges=%0d cause=%0d cnt=%0d, want 27 %0d %0d",
                     edges, cause_o, cycle_count_o, e.cause, e.count);
        end
    endtask

    // PC changes until cycle 52, then holds: stall limit and timeout both land on cycle 60.
    task automatic test_simultaneous;
        int   edges;
        exp_t e;
        for (int h = 1; h >= 0; h--) begin
            edges = 0;
            sb.push_back('{cause: (h == 1) ? 2'd1 : 2'd2, count: CYCLE_W'(60)});
            start_run("simul");
            for (int c = 1; c <= 70; c++) begin
                pc_valid_i = 1'b1;
                pc_i       = PC_W'((c < 52) ? 4 * c : 208);
                halt_i     = (h == 1) && (c == 60);
                tick();
                if (done_o) begin edges = c; break; end
            end
            halt_i     = 1'b0;
            pc_valid_i = 1'b0;
            e = sb.pop_front();
            n_tests++;
            if (edges != 60 || cause_o !== e.cause || cycle_count_o !== e.count) begin
                n_fail++;
                $display("FAIL simul_h%0d: edges=%0d cause=%0d cnt=%0d, want 60 %0d %0d",
                         h, edges, cause_o, cycle_count_o, e.cause, e.count);
            end
        end
    endtask

    task automatic test_async_reset;
        int   edges;
        exp_t e;
        start_run("async");
        for (int c = 1; c <= 5; c++) begin
            pc_valid_i = 1'b1;
            pc_i       = PC_W'(32'h3000 + 4 * c);
            tick();
        end
        #3;
        RST = 1'b1;
        #1;
        n_tests++;
        if (core_rst_o !== 1'b1 || running_o !== 1'b0 || done_o !== 1'b0 ||
            cause_o !== 2'd0 || cycle_count_o !== '0) begin
            n_fail++;
            $display("FAIL async_rst: rst=%b run=%b done=%b cause=%0d cnt=%0d, want 1 0 0 0 0",
                     core_rst_o, running_o, done_o, cause_o, cycle_count_o);
        end
        tick();
        RST = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (core_rst_o !== 1'b1 || running_o !== 1'b0 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL post_rst_idle: rst=%b run=%b done=%b, want 1 0 0", core_rst_o, running_o, done_o);
        end
        edges = 0;
        sb.push_back('{cause: 2'd1, count: CYCLE_W'(3)});
        start_run("post_rst");
        for (int c = 1; c <= 70; c++) begin
            pc_i   = PC_W'(32'h4000 + 4 * c);
            halt_i = (c == 3);
            tick();
            if (done_o) begin edges = c; break; end
        end
        halt_i     = 1'b0;
        pc_valid_i = 1'b0;
        e = sb.pop_front();
        n_tests++;
        if (edges != 3 || cause_o !== e.cause || cycle_count_o !== e.count) begin
            n_fail++;
            $display("FAIL post_rst_run: edges=%0d cause=%0d cnt=%0d, want 3 %0d %0d",
                     edges, cause_o, cycle_count_o, e.cause, e.count);
        end
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_halt();
        test_stall();
        test_simultaneous();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

endmodule
